stage_mem_lsu: RTL and testbench

Parametrised memory-stage load/store unit that replaces the fixed-width single-cycle memory stage between EX/MEM and MEM/WB. Handles byte/half/word/double accesses with sign or zero extension and byte strobes. Talks to data memory over a valid/ready request channel with variable-latency responses, and back-pressures EX while an access is in flight. Flags misaligned accesses instead of issuing them.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_load_align.sv | 48 ++++
 rtl/stage_mem_lsu.sv | 197 +++++++++++++++++++
 tb/tb_stage_mem_lsu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
//   size_e       : access size encoding (byte/half/word/double)
//   state_e      : request FSM states
//   make_wstrb   : byte-enable pattern for a size at a lane offset
//   is_misaligned: address not a multiple of the access size
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  // Widest strobe vector supported (64-bit bus).
  localparam int MAX_STRB_W = 8;

  function automatic logic [MAX_STRB_W-1:0] make_wstrb(input size_e size,
                                                       input logic [2:0] offset);
    logic [MAX_STRB_W-1:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] addr_lo, input size_e size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed lane of a full bus word,
// masks it to the access size and sign- or zero-extends to DATA_WIDTH.
//   rdata       : full bus word from memory
//   offset      : byte offset of the access within the bus word
//   size        : access size (size_e encoding)
//   is_unsigned : zero-extend instead of sign-extend
//   data        : aligned, extended result
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]  offset,
  input  logic [1:0]                       size,
  input  logic                             is_unsigned,
  output logic [DATA_WIDTH-1:0]            data
);

  logic [DATA_WIDTH-1:0] lane;
  logic signed [7:0]     b_s;
  logic signed [15:0]    h_s;
  logic signed [31:0]    w_s;

  always_comb begin
    lane = rdata >> {offset, 3'b000};
    b_s  = lane[7:0];
    h_s  = lane[15:0];
    w_s  = lane[31:0];
    data = lane;
    case (size_e'(size))
      SZ_B: begin
        if (is_unsigned) data = DATA_WIDTH'(lane[7:0]);
        else             data = DATA_WIDTH'(b_s);
      end
      SZ_H: begin
        if (is_unsigned) data = DATA_WIDTH'(lane[15:0]);
        else             data = DATA_WIDTH'(h_s);
      end
      SZ_W: begin
        if (is_unsigned) data = DATA_WIDTH'(lane[31:0]);
        else             data = DATA_WIDTH'(w_s);
      end
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// Memory-stage load/store unit between EX/MEM and MEM/WB.
// Accepts one op per cycle while idle; memory ops issue a valid/ready
// request, loads then wait for a variable-latency response. Misaligned
// ops are reported as faults instead of being issued.
//   clk, reset        : clock, synchronous active-high reset
//   in_*              : EX/MEM op (in_ready low stalls EX)
//   mem_req_*         : data memory request channel (bus-aligned address,
//                       lane-replicated write data, byte strobes)
//   mem_rsp_*         : load response (full bus word)
//   out_*             : MEM/WB entry, out_valid pulses once per op
//   misalign_fault    : pulses with out_valid of a faulting op
//   fault_addr        : address of the most recent fault
module stage_mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int REG_NUM    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_alu_result,
  input  logic [DATA_WIDTH-1:0]        in_store_data,
  input  logic [$clog2(REG_NUM)-1:0]   in_rd,
  input  logic                         in_mem_read,
  input  logic                         in_mem_write,
  input  logic                         in_reg_write,
  input  logic [1:0]                   in_size,
  input  logic                         in_unsigned,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  output logic                         mem_req_we,
  output logic [DATA_WIDTH-1:0]        mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]      mem_req_wstrb,
  input  logic                         mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]        mem_rsp_rdata,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_alu_result,
  output logic [DATA_WIDTH-1:0]        out_mem_data,
  output logic [$clog2(REG_NUM)-1:0]   out_rd,
  output logic                         out_reg_write,
  output logic                         out_mem2reg,
  output logic                         misalign_fault,
  output logic [ADDR_WIDTH-1:0]        fault_addr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int RD_W   = $clog2(REG_NUM);

  state_e state_q, state_d;

  logic                  accept;
  logic                  is_mem_op;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [STRB_W-1:0]     wstrb_d;
  logic [DATA_WIDTH-1:0] load_data;

  logic [DATA_WIDTH-1:0] alu_p0;
  logic [RD_W-1:0]       rd_p0;
  logic                  rw_p0;
  logic                  uns_p0;
  logic [1:0]            size_p0;
  logic [OFF_W-1:0]      off_p0;

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign accept        = in_ready & in_valid;
  assign is_mem_op     = in_mem_read | in_mem_write;
  assign in_addr       = ADDR_WIDTH'(in_alu_result);

  // A double access cannot be served by a 32-bit bus, so it is treated
  // like any other unservable alignment.
  assign fault = is_misaligned(in_alu_result[2:0], size_e'(in_size)) ||
                 ((DATA_WIDTH == 32) && (in_size == 2'd3));

  assign wstrb_d = STRB_W'(make_wstrb(size_e'(in_size), 3'(in_alu_result[OFF_W-1:0])));

  // Replicate the right-aligned store bytes into every lane so memory can
  // pick them up wherever the strobes point.
  always_comb begin
    wdata_rep = '0;
    for (int i = 0; i < STRB_W; i++) begin
      case (size_e'(in_size))
        SZ_B:    wdata_rep[8*i +: 8] = in_store_data[7:0];
        SZ_H:    wdata_rep[8*i +: 8] = in_store_data[8*(i%2) +: 8];
        SZ_W:    wdata_rep[8*i +: 8] = in_store_data[8*(i%4) +: 8];
        default: wdata_rep[8*i +: 8] = in_store_data[8*i +: 8];
      endcase
    end
  end

  lsu_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .rdata       (mem_rsp_rdata),
    .offset      (off_p0),
    .size        (size_p0),
    .is_unsigned (uns_p0),
    .data        (load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && is_mem_op && !fault) state_d = REQ;
      REQ:     if (mem_req_ready) state_d = mem_req_we ? IDLE : RSP;
      RSP:     if (mem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stage p0: op captured at accept, held for the life of the access
  always_ff @(posedge clk) begin
    if (accept) begin
      alu_p0  <= in_alu_result;
      rd_p0   <= in_rd;
      rw_p0   <= in_reg_write;
      uns_p0  <= in_unsigned;
      size_p0 <= in_size;
      off_p0  <= in_alu_result[OFF_W-1:0];
    end
  end

  // Stage p1: request fields and MEM/WB outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_addr   <= '0;
      mem_req_we     <= 1'b0;
      mem_req_wdata  <= '0;
      mem_req_wstrb  <= '0;
      out_valid      <= 1'b0;
      out_alu_result <= '0;
      out_mem_data   <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem2reg    <= 1'b0;
      misalign_fault <= 1'b0;
      fault_addr     <= '0;
    end else begin
      out_valid      <= 1'b0;
      misalign_fault <= 1'b0;
      if (accept) begin
        if (!is_mem_op) begin
          out_valid      <= 1'b1;
          out_alu_result <= in_alu_result;
          out_mem_data   <= '0;
          out_rd         <= in_rd;
          out_reg_write  <= in_reg_write && (in_rd != '0);
          out_mem2reg    <= 1'b0;
        end else if (fault) begin
          out_valid      <= 1'b1;
          misalign_fault <= 1'b1;
          fault_addr     <= in_addr;
          out_alu_result <= in_alu_result;
          out_mem_data   <= '0;
          out_rd         <= in_rd;
          out_reg_write  <= 1'b0;
          out_mem2reg    <= 1'b0;
        end else begin
          mem_req_addr  <= {in_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          mem_req_we    <= in_mem_write;
          mem_req_wdata <= wdata_rep;
          mem_req_wstrb <= wstrb_d;
        end
      end
      // Stores are posted: complete on the request handshake.
      if ((state_q == REQ) && mem_req_ready && mem_req_we) begin
        out_valid      <= 1'b1;
        out_alu_result <= alu_p0;
        out_mem_data   <= '0;
        out_rd         <= rd_p0;
        out_reg_write  <= 1'b0;
        out_mem2reg    <= 1'b0;
      end
      if ((state_q == RSP) && mem_rsp_valid) begin
        out_valid      <= 1'b1;
        out_alu_result <= alu_p0;
        out_mem_data   <= load_data;
        out_rd         <= rd_p0;
        out_reg_write  <= rw_p0 && (rd_p0 != '0);
        out_mem2reg    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Scoreboard bench for stage_mem_lsu: a 64-bit instance carries most of
// the directed vectors, a 32-bit instance covers the narrow-bus cases.
module tb_stage_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] mem;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];
  exp_t e64, e32;

  // 64-bit instance signals
  logic        reset, in_valid, in_ready, in_mem_read, in_mem_write, in_reg_write, in_unsigned;
  logic [63:0] in_alu_result, in_store_data, mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [63:0] out_alu_result, out_mem_data, fault_addr;
  logic [4:0]  in_rd, out_rd;
  logic [1:0]  in_size;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [7:0]  mem_req_wstrb;
  logic        out_valid, out_reg_write, out_mem2reg, misalign_fault;

  // 32-bit instance signals
  logic        reset_b, in_valid_b, in_ready_b, in_mem_read_b, in_mem_write_b, in_reg_write_b, in_unsigned_b;
  logic [31:0] in_alu_result_b, in_store_data_b, mem_req_addr_b, mem_req_wdata_b, mem_rsp_rdata_b;
  logic [31:0] out_alu_result_b, out_mem_data_b, fault_addr_b;
  logic [4:0]  in_rd_b, out_rd_b;
  logic [1:0]  in_size_b;
  logic        mem_req_valid_b, mem_req_ready_b, mem_req_we_b, mem_rsp_valid_b;
  logic [3:0]  mem_req_wstrb_b;
  logic        out_valid_b, out_reg_write_b, out_mem2reg_b, misalign_fault_b;

  stage_mem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .REG_NUM(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_rd(in_rd),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_alu_result(out_alu_result), .out_mem_data(out_mem_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem2reg(out_mem2reg),
    .misalign_fault(misalign_fault), .fault_addr(fault_addr)
  );

  stage_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_NUM(32)) dut32 (
    .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_alu_result(in_alu_result_b), .in_store_data(in_store_data_b), .in_rd(in_rd_b),
    .in_mem_read(in_mem_read_b), .in_mem_write(in_mem_write_b), .in_reg_write(in_reg_write_b),
    .in_size(in_size_b), .in_unsigned(in_unsigned_b),
    .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready_b), .mem_req_addr(mem_req_addr_b),
    .mem_req_we(mem_req_we_b), .mem_req_wdata(mem_req_wdata_b), .mem_req_wstrb(mem_req_wstrb_b),
    .mem_rsp_valid(mem_rsp_valid_b), .mem_rsp_rdata(mem_rsp_rdata_b),
    .out_valid(out_valid_b), .out_alu_result(out_alu_result_b), .out_mem_data(out_mem_data_b),
    .out_rd(out_rd_b), .out_reg_write(out_reg_write_b), .out_mem2reg(out_mem2reg_b),
    .misalign_fault(misalign_fault_b), .fault_addr(fault_addr_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expectation per out_valid pulse.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q64.size() == 0) chk("unexpected_out_valid64", 64'd1, 64'd0);
      else begin
        e64 = q64.pop_front();
        chk("latency64", 64'(cyc), 64'(e64.cyc));
        chk("out_alu64", out_alu_result, e64.alu);
        chk("out_mem64", out_mem_data, e64.mem);
        chk("out_rd64", 64'(out_rd), 64'(e64.rd));
        chk("out_reg_write64", 64'(out_reg_write), 64'(e64.rw));
        chk("out_mem2reg64", 64'(out_mem2reg), 64'(e64.m2r));
        chk("misalign64", 64'(misalign_fault), 64'(e64.fault));
        if (e64.fault) chk("fault_addr64", fault_addr, e64.alu);
      end
    end else if (misalign_fault) chk("stray_fault64", 64'd1, 64'd0);
  end

  always @(negedge clk) begin
    if (out_valid_b) begin
      if (q32.size() == 0) chk("unexpected_out_valid32", 64'd1, 64'd0);
      else begin
        e32 = q32.pop_front();
        chk("latency32", 64'(cyc), 64'(e32.cyc));
        chk("out_alu32", 64'(out_alu_result_b), e32.alu);
        chk("out_mem32", 64'(out_mem_data_b), e32.mem);
        chk("out_rd32", 64'(out_rd_b), 64'(e32.rd));
        chk("out_reg_write32", 64'(out_reg_write_b), 64'(e32.rw));
        chk("out_mem2reg32", 64'(out_mem2reg_b), 64'(e32.m2r));
        chk("misalign32", 64'(misalign_fault_b), 64'(e32.fault));
        if (e32.fault) chk("fault_addr32", 64'(fault_addr_b), e32.alu);
      end
    end
  end

  // Present one op to the 64-bit instance for exactly one accept edge.
  task automatic issue(input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd,
                       input logic rdf, input logic wrf, input logic rwf, input logic [1:0] sz,
                       input logic uns, input logic push, input logic [63:0] e_mem,
                       input logic e_rw, input logic e_m2r, input logic e_fault, input int lat);
    exp_t e;
    chk("in_ready_at_issue", 64'(in_ready), 64'd1);
    in_alu_result = alu; in_store_data = sd; in_rd = rd;
    in_mem_read = rdf; in_mem_write = wrf; in_reg_write = rwf;
    in_size = sz; in_unsigned = uns; in_valid = 1'b1;
    if (push) begin
      e.alu = alu; e.mem = e_mem; e.rd = rd; e.rw = e_rw; e.m2r = e_m2r;
      e.fault = e_fault; e.cyc = cyc + lat;
      q64.push_back(e);
    end
    tick();
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;
  endtask

  task automatic chk_req(input string nm, input logic [63:0] addr, input logic we,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
    chk({nm, "_req_valid"}, 64'(mem_req_valid), 64'd1);
    chk({nm, "_req_addr"}, mem_req_addr, addr);
    chk({nm, "_req_we"}, 64'(mem_req_we), 64'(we));
    chk({nm, "_req_wdata"}, mem_req_wdata, wdata);
    chk({nm, "_req_wstrb"}, 64'(mem_req_wstrb), 64'(wstrb));
  endtask

  // Memory side of a load: handshake after hold_low cycles, respond after rsp_wait more.
  task automatic mem_load(input int hold_low, input int rsp_wait, input logic [63:0] data);
    repeat (hold_low) tick();
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    repeat (rsp_wait) tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = data; tick();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b1; in_valid = 0; in_alu_result = 0; in_store_data = 0; in_rd = 0;
    in_mem_read = 0; in_mem_write = 0; in_reg_write = 0; in_size = 0; in_unsigned = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    reset_b = 1'b1; in_valid_b = 0; in_alu_result_b = 0; in_store_data_b = 0; in_rd_b = 0;
    in_mem_read_b = 0; in_mem_write_b = 0; in_reg_write_b = 0; in_size_b = 0; in_unsigned_b = 0;
    mem_req_ready_b = 0; mem_rsp_valid_b = 0; mem_rsp_rdata_b = 0;
    repeat (3) tick();
    reset = 1'b0; reset_b = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_fault_addr", fault_addr, 64'd0);
    chk("rst_out_alu", out_alu_result, 64'd0);

    // ALU ops, including back-to-back and rd=0
    issue(64'h1234, 0, 5'd5, 0, 0, 1, 2'd3, 0, 1, 64'd0, 1, 0, 0, 1);
    chk("alu_no_req", 64'(mem_req_valid), 64'd0);
    issue(64'hAAAA, 0, 5'd7, 0, 0, 1, 2'd0, 0, 1, 64'd0, 1, 0, 0, 1);
    issue(64'h5555, 0, 5'd0, 0, 0, 1, 2'd0, 0, 1, 64'd0, 0, 0, 0, 1);

    // Byte loads at 0x1003, signed then unsigned
    issue(64'h1003, 0, 5'd10, 1, 0, 1, 2'd0, 0, 1, 64'hFFFFFFFF_FFFFFF80, 1, 1, 0, 3);
    chk("ldb_busy", 64'(in_ready), 64'd0);
    chk_req("ldb", 64'h1000, 0, 64'd0, 8'h08);
    mem_load(0, 0, 64'h00000000_80000000);
    issue(64'h1003, 0, 5'd11, 1, 0, 1, 2'd0, 1, 1, 64'h80, 1, 1, 0, 3);
    mem_load(0, 0, 64'h00000000_80000000);

    // Half store at 0x2006 with ready low for 3 cycles
    issue(64'h2006, 64'h12345678_9ABCBEEF, 5'd3, 0, 1, 1, 2'd1, 0, 1, 64'd0, 0, 0, 0, 5);
    for (int i = 0; i < 3; i++) begin
      chk_req("sth_stall", 64'h2000, 1, 64'hBEEFBEEF_BEEFBEEF, 8'hC0);
      tick();
    end
    chk_req("sth_hs", 64'h2000, 1, 64'hBEEFBEEF_BEEFBEEF, 8'hC0);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;

    // Byte store at 0x7005, ready immediately
    issue(64'h7005, 64'hFFFF_FFA5, 5'd0, 0, 1, 0, 2'd0, 0, 1, 64'd0, 0, 0, 0, 2);
    chk_req("stb", 64'h7000, 1, 64'hA5A5A5A5_A5A5A5A5, 8'h20);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;

    // Misaligned word load at 0x3002
    issue(64'h3002, 0, 5'd4, 1, 0, 1, 2'd2, 0, 1, 64'd0, 0, 0, 1, 1);
    chk("mis_no_req", 64'(mem_req_valid), 64'd0);
    issue(64'h42, 0, 5'd1, 0, 0, 1, 2'd0, 0, 1, 64'd0, 1, 0, 0, 1);
    chk("fault_addr_hold", fault_addr, 64'h3002);

    // Word load at 0x4004; a response pulse during REQ must be ignored
    issue(64'h4004, 0, 5'd6, 1, 0, 1, 2'd2, 0, 1, 64'hFFFFFFFF_89ABCDEF, 1, 1, 0, 6);
    chk_req("ldw", 64'h4000, 0, 64'd0, 8'hF0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEADBEEF_DEADBEEF; tick();
    mem_rsp_valid = 1'b0;
    mem_load(0, 2, 64'h89ABCDEF_01234567);

    // Double load to rd=0, unsigned half load
    issue(64'h5000, 0, 5'd0, 1, 0, 1, 2'd3, 0, 1, 64'hFEDCBA98_76543210, 0, 1, 0, 3);
    chk_req("ldd", 64'h5000, 0, 64'd0, 8'hFF);
    mem_load(0, 0, 64'hFEDCBA98_76543210);
    issue(64'h6002, 0, 5'd9, 1, 0, 1, 2'd1, 1, 1, 64'h0000F00D, 1, 1, 0, 3);
    chk_req("ldhu", 64'h6000, 0, 64'd0, 8'h0C);
    mem_load(0, 0, 64'h00000000_F00D0000);

    // Reset while waiting for a response, then a late response
    issue(64'h8000, 0, 5'd12, 1, 0, 1, 2'd2, 0, 0, 64'd0, 0, 0, 0, 0);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    chk("rsp_busy", 64'(in_ready), 64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_fault_addr", fault_addr, 64'd0);
    chk("midrst_req_valid", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1111_2222_3333_4444; tick();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_no_out", 64'(out_valid), 64'd0);
    tick();
    issue(64'h99, 0, 5'd2, 0, 0, 1, 2'd0, 0, 1, 64'd0, 1, 0, 0, 1);

    // 32-bit bus: double access faults, signed half load at 0x9006
    chk("d32_in_ready", 64'(in_ready_b), 64'd1);
    in_alu_result_b = 32'h9000; in_rd_b = 5'd8; in_mem_read_b = 1; in_reg_write_b = 1;
    in_size_b = 2'd3; in_valid_b = 1'b1;
    e.alu = 64'h9000; e.mem = 0; e.rd = 5'd8; e.rw = 0; e.m2r = 0; e.fault = 1; e.cyc = cyc + 1;
    q32.push_back(e);
    tick();
    chk("d32_dbl_no_req", 64'(mem_req_valid_b), 64'd0);
    in_alu_result_b = 32'h9006; in_size_b = 2'd1; in_unsigned_b = 0;
    e.alu = 64'h9006; e.mem = 64'hFFFF8001; e.rd = 5'd8; e.rw = 1; e.m2r = 1; e.fault = 0;
    e.cyc = cyc + 3;
    q32.push_back(e);
    tick();
    in_valid_b = 1'b0; in_mem_read_b = 0; in_reg_write_b = 0;
    chk("d32_req_valid", 64'(mem_req_valid_b), 64'd1);
    chk("d32_req_addr", 64'(mem_req_addr_b), 64'h9004);
    chk("d32_req_wstrb", 64'(mem_req_wstrb_b), 64'hC);
    mem_req_ready_b = 1'b1; tick(); mem_req_ready_b = 1'b0;
    mem_rsp_valid_b = 1'b1; mem_rsp_rdata_b = 32'h8001_0000; tick();
    mem_rsp_valid_b = 1'b0;

    repeat (4) tick();
    chk("q64_drained", 64'(q64.size()), 64'd0);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
